// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Multiplies retire MUL_BITS multiplier bits per cycle (shift-add). Divides use a
// restoring algorithm that produces one quotient bit per cycle. A final FIX cycle
// applies the sign correction and commits HI/LO. mthi/mtlo and flush abort any
// in-flight operation.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [CNT_W-1:0]   MUL_LAST = CNT_W'(WIDTH / MUL_BITS - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2 * WIDTH)'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] iterCnt;
    logic [WIDTH-1:0] workHi;    // MUL: running upper product; DIV: partial remainder
    logic [WIDTH-1:0] workLo;    // MUL: multiplier / low product; DIV: dividend -> quotient
    logic [WIDTH-1:0] operand;   // MUL: |multiplicand|; DIV: |divisor|
    logic [WIDTH-1:0] rawA;      // unmodified dividend for the divide-by-zero result
    logic             opDiv;
    logic             negResult;
    logic             negRem;
    logic             divZero;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             doneReg;

    logic                      signedOp;
    logic                      negA;
    logic                      negB;
    logic [WIDTH-1:0]          magA;
    logic [WIDTH-1:0]          magB;
    logic                      abort;
    logic [MUL_BITS-1:0]       digit;
    logic [WIDTH+MUL_BITS-1:0] partial;
    logic [WIDTH:0]            shifted;
    logic                      geq;
    logic [WIDTH-1:0]          divDiff;
    logic [2*WIDTH-1:0]        prodOut;
    logic [WIDTH-1:0]          quotOut;
    logic [WIDTH-1:0]          remOut;

    assign busy = (state != IDLE);
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

    // Operand magnitudes and per-iteration datapath for both algorithms
    always_comb begin
        signedOp = ~op[0];
        negA     = signedOp & srca[WIDTH-1];
        negB     = signedOp & srcb[WIDTH-1];
        // Read as unsigned, the W-bit negation of the most-negative value is its
        // exact magnitude, so no extra bit is needed to hold it.
        magA     = negA ? (~srca + ONE_W) : srca;
        magB     = negB ? (~srcb + ONE_W) : srcb;
        abort    = flush | mthi | mtlo;

        digit   = workLo[MUL_BITS-1:0];
        partial = {{MUL_BITS{1'b0}}, workHi}
                + ({{MUL_BITS{1'b0}}, operand} * {{WIDTH{1'b0}}, digit});

        shifted = {workHi, workLo[WIDTH-1]};
        geq     = (shifted >= {1'b0, operand});
        // When geq holds the true difference is below the divisor, so W bits suffice.
        divDiff = shifted[WIDTH-1:0] - operand;

        prodOut = negResult ? (~{workHi, workLo} + ONE_2W) : {workHi, workLo};
        quotOut = negResult ? (~workLo + ONE_W) : workLo;
        remOut  = negRem ? (~workHi + ONE_W) : workHi;
    end

    // Sequencer, iteration datapath and HI/LO commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            iterCnt   <= '0;
            workHi    <= '0;
            workLo    <= '0;
            operand   <= '0;
            rawA      <= '0;
            opDiv     <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (mthi) hiReg <= wdata;
            if (mtlo) loReg <= wdata;

            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opDiv     <= op[1];
                            negResult <= negA ^ negB;
                            negRem    <= negA;
                            divZero   <= (srcb == '0);
                            rawA      <= srca;
                            workHi    <= '0;
                            if (op[1]) begin
                                state   <= DIV;
                                iterCnt <= DIV_LAST;
                                workLo  <= magA;
                                operand <= magB;
                            end else begin
                                state   <= MUL;
                                iterCnt <= MUL_LAST;
                                workLo  <= magB;
                                operand <= magA;
                            end
                        end
                    end
                    MUL: begin
                        workHi  <= partial[WIDTH+MUL_BITS-1:MUL_BITS];
                        workLo  <= {partial[MUL_BITS-1:0], workLo[WIDTH-1:MUL_BITS]};
                        iterCnt <= iterCnt - CNT_ONE;
                        if (iterCnt == '0) state <= FIX;
                    end
                    DIV: begin
                        workHi  <= geq ? divDiff : shifted[WIDTH-1:0];
                        workLo  <= {workLo[WIDTH-2:0], geq};
                        iterCnt <= iterCnt - CNT_ONE;
                        if (iterCnt == '0) state <= FIX;
                    end
                    default: begin
                        if (opDiv) begin
                            if (divZero) begin
                                loReg <= '1;
                                hiReg <= rawA;
                            end else begin
                                loReg <= quotOut;
                                hiReg <= remOut;
                            end
                        end else begin
                            {hiReg, loReg} <= prodOut;
                        end
                        doneReg <= 1'b1;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
